// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: picks sequential/hold/redirect PC and raises IF/ID flushes.
// Latency: combinational from inputs/state to CurrPC/PChold/Flush*, state updates on posedge Clk.
// Backpressure: ImemReady=0 holds the PC and defers any redirect until memory accepts a fetch.
// Optional build macro REDIRECT_STATS_EN adds RedirCnt/StallCnt saturating counters.
module fetch_redirect_ctrl #(
    parameter int AW        = 16,
    parameter int FLUSH_CYC = 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [AW-1:0] PcQ,
    input  logic          ImemReady,
    input  logic          LoadUse,
    input  logic          JmpReq,
    input  logic [AW-1:0] JmpTarget,
    input  logic          BrTaken,
    input  logic [AW-1:0] BrTarget,
    output logic [AW-1:0] CurrPC,
    output logic          PChold,
    output logic          FlushIF,
    output logic          FlushID,
    output logic          Busy
`ifdef REDIRECT_STATS_EN
    ,
    output logic [15:0]   RedirCnt,
    output logic [15:0]   StallCnt
`endif
);

    typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_FLUSH} state_t;

    // Count of FLUSH-state cycles that follow the cycle the redirect is applied in.
    localparam logic [1:0] CNT_INIT    = 2'(FLUSH_CYC - 1);
    localparam bit         FLUSH_MULTI = (FLUSH_CYC > 1);

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_pend_pc, w_pend_pc_nxt;
    logic          r_pend_br, w_pend_br_nxt;
    logic [1:0]    r_cnt, w_cnt_nxt;

    logic          w_req;
    logic [AW-1:0] w_req_tgt;
    logic          w_stall;
    logic          w_apply;
    logic          w_capture;
    logic [AW-1:0] w_tgt;
    logic          w_tgt_br;

    // A branch outranks a same-cycle jump: the jump belongs to a younger instruction.
    assign w_req     = BrTaken | JmpReq;
    assign w_req_tgt = BrTaken ? BrTarget : JmpTarget;
    assign w_stall   = LoadUse | ~ImemReady;

    // State, pending redirect and flush counter registers.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state   <= ST_RUN;
            r_pend_pc <= '0;
            r_pend_br <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_pc <= w_pend_pc_nxt;
            r_pend_br <= w_pend_br_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Next-state and PC/flush output selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_pend_pc_nxt = r_pend_pc;
        w_pend_br_nxt = r_pend_br;
        w_cnt_nxt     = r_cnt;
        w_apply       = 1'b0;
        w_capture     = 1'b0;
        w_tgt         = '0;
        w_tgt_br      = 1'b0;
        CurrPC        = PcQ;
        PChold        = 1'b0;
        FlushIF       = 1'b0;
        FlushID       = 1'b0;
        Busy          = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_req) begin
                    if (ImemReady) begin
                        w_apply  = 1'b1;
                        w_tgt    = w_req_tgt;
                        w_tgt_br = BrTaken;
                    end else begin
                        w_capture     = 1'b1;
                        w_pend_pc_nxt = w_req_tgt;
                        w_pend_br_nxt = BrTaken;
                        w_state_nxt   = ST_PEND;
                        PChold        = 1'b1;
                    end
                end else begin
                    PChold = w_stall;
                end
            end
            ST_PEND: begin
                // Jumps are dropped here; only a newer branch may replace the target.
                if (ImemReady) begin
                    w_apply  = 1'b1;
                    w_tgt    = BrTaken ? BrTarget : r_pend_pc;
                    w_tgt_br = BrTaken | r_pend_br;
                end else begin
                    PChold = 1'b1;
                    if (BrTaken) begin
                        w_pend_pc_nxt = BrTarget;
                        w_pend_br_nxt = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                FlushIF = 1'b1;
                // Jumps are ignored: the jumping instruction is itself being squashed.
                if (BrTaken) begin
                    if (ImemReady) begin
                        w_apply  = 1'b1;
                        w_tgt    = BrTarget;
                        w_tgt_br = 1'b1;
                    end else begin
                        w_capture     = 1'b1;
                        w_pend_pc_nxt = BrTarget;
                        w_pend_br_nxt = 1'b1;
                        w_state_nxt   = ST_PEND;
                        PChold        = 1'b1;
                    end
                end else begin
                    PChold    = w_stall;
                    w_cnt_nxt = r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // Redirect: PC register holds so it loads the target unchanged.
        if (w_apply) begin
            CurrPC  = w_tgt;
            PChold  = 1'b1;
            FlushIF = 1'b1;
            FlushID = w_tgt_br;
            if (FLUSH_MULTI) begin
                w_state_nxt = ST_FLUSH;
                w_cnt_nxt   = CNT_INIT;
            end else begin
                w_state_nxt = ST_RUN;
            end
        end

        if (!Rst) begin
            CurrPC    = '0;
            PChold    = 1'b1;
            FlushIF   = 1'b0;
            FlushID   = 1'b0;
            w_apply   = 1'b0;
            w_capture = 1'b0;
        end

        Busy = Rst & ((r_state != ST_RUN) | FlushIF | w_capture);
    end

`ifdef REDIRECT_STATS_EN
    logic [15:0] r_redir_cnt;
    logic [15:0] r_stall_cnt;

    // Saturating counters of applied redirects and of non-redirect hold cycles.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_redir_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_apply && (r_redir_cnt != 16'hFFFF)) begin
                r_redir_cnt <= r_redir_cnt + 16'd1;
            end
            if (PChold && !w_apply && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign RedirCnt = r_redir_cnt;
    assign StallCnt = r_stall_cnt;
`endif

endmodule
